imm_decode_stage: RTL and testbench
===================================

# imm_decode_stage

Decode-stage immediate controller for the 16-bit pipeline CPU. It accepts fetched instructions over a valid/ready handshake, decodes the opcode into the 4-bit immediate source select, and produces the extended 16-bit immediate. It buffers results in a 2-entry skid buffer so that stall back-pressure from the execute stage never drops or duplicates an instruction. It sits between the IF/ID register and the ID/EX register and honours branch flush.

## Interface
- `NOP_INSTR`, default 16'h0800: instruction word presented on `instr_out` when no entry is valid.
- `clk`  in  1: rising-edge clock.
- `rst`  in  1: asynchronous, active-low reset.
- `in_valid`  in  1: `in_instr` holds a fetched instruction.
- `in_ready`  out  1: the block can accept an instruction this cycle.
- `in_instr`  in  16: fetched instruction.
- `flush`  in  1: squash all buffered instructions (branch taken).
- `out_valid`  out  1: the head entry is valid.
- `out_ready`  in  1: the execute stage accepts the head entry.
- `instr_out`  out  16: head instruction.
- `im_src_sel`  out  4: head immediate select. Bit 3 set means sign-extend; bits [2:0] give the field.
- `imm_out`  out  16: head extended immediate.
- `has_imm`  out  1: the head opcode uses an immediate.

## Operation
- Immediate select field codes, as `im_src_sel[2:0]`:
  - 000: [7:0]
  - 001: [3:0]
  - 010: [4:0]
  - 011: [10:0]
  - 100: [4:2]
  - 101: shift amount [4:2], where 0 maps to 8
- Extension: zero-extend when bit 3 is 0, sign-extend from the field MSB when bit 3 is 1. Code 1101 never occurs; it is treated as 0101.
- Opcode decode on `instr[15:11]`:
  - Select 1000 (imm8, signed): 01001 ADDIU, 00000 ADDSP3, 00100 BEQZ, 00101 BNEZ, 01110 CMPI, 10010 LW_SP, 11010 SW_SP, 01100 (ADDSP/BTEQZ).
  - 01000 ADDIU3: select 1001.
  - 10011 LW and 11011 SW: select 1010.
  - 00010 B: select 1011.
  - 01101 LI: select 0000.
  - 00110 shifts: select 0101.
  - All other opcodes: `has_imm`=0, select 0000, `imm_out`=0.
- Decode and extension are combinational on `in_instr` and are captured into the entry at acceptance. The stored entry fields are instr, select, imm, has_imm, and valid.
- The skid buffer has two entries, head and tail, and an occupancy count from 0 to 2.
  - `in_ready` = (count < 2). It is registered-derived, with no combinational path from `out_ready`.
  - Accept occurs when `in_valid` and `in_ready` are both high. Pop occurs when `out_valid` and `out_ready` are both high.
  - Accept and pop in the same cycle leave count unchanged; the new entry lands behind the remaining one.
  - When count is 0, the accepted entry goes to head.
- `flush` is sampled at the clock edge. It invalidates both entries (count becomes 0) and has priority over a simultaneous accept and pop: the accepted instruction is discarded.
- Counter states are EMPTY (0), ONE (1), and FULL (2):
  - From EMPTY: accept goes to ONE.
  - From ONE: accept without pop goes to FULL; pop without accept goes to EMPTY; accept with pop stays in ONE.
  - From FULL: pop goes to ONE. Accept is impossible because `in_ready` is 0.
  - From any state: flush goes to EMPTY.
- When `out_valid` is 0, the outputs read `instr_out`=`NOP_INSTR`, `im_src_sel`=0, `imm_out`=0, `has_imm`=0.

## Timing
- Latency is 1 cycle: an instruction accepted at edge N is visible on the outputs after edge N when the buffer was empty.
- Throughput is one instruction per cycle while `out_ready` stays high.
- Reset values: count 0, `out_valid` 0, `in_ready` 1, `instr_out`=`NOP_INSTR`, all other outputs 0. Assertion is asynchronous; release takes effect at the next edge.
- Reset asserted mid-operation discards all entries immediately.
- While `out_valid`=1 and `out_ready`=0, all head outputs are held stable.
- Ordering is strict FIFO, with no reordering or duplication.

## Structure
- A shared package `imm_pkg` holds:
  - opcode constants
  - the select encodings (`IMM_U8`, `IMM_S8`, `IMM_S4`, `IMM_S5`, `IMM_S11`, `IMM_SHAMT`)
  - the entry struct typedef
  - `NOP_INSTR`
- One sub-module, `imm_extend`, is purely combinational: select plus instruction in, 16-bit immediate out. The buffer and the decode stay in the top module.

## Test plan
- Reset, then `in_instr`=16'h4F80 (ADDIU, imm 0x80) with `out_ready`=1 → next cycle `im_src_sel`=4'b1000, `imm_out`=16'hFF80, `has_imm`=1.
- SLL with [4:2]=000, then LI 16'h6DFF → `imm_out`=16'h0008 (select 0101), then 16'h00FF (select 0000).
- Issue B 16'h1400 and SW 16'hDF10 back-to-back with `out_ready`=0 for 3 cycles:
  - `in_ready` drops after 2 accepts.
  - After `out_ready` goes high, the outputs are B (16'hFC00), then SW (16'hFFF0), in order with no loss.
- `flush` asserted with count=2 and `in_valid`=1 simultaneously → next cycle `out_valid`=0, `in_ready`=1, the flushed instructions never appear, and `instr_out`=`NOP_INSTR`.
- Assert `rst` low mid-stream while FULL → outputs take their reset values immediately (without a clock edge), and the first instruction accepted after release is the first presented.
- Random valid/ready traffic over all opcodes against a reference decode model → the output sequence equals the accepted sequence minus flushed entries.

Source files
------------

// File: rtl/imm_pkg.sv
// imm_pkg: shared definitions for the decode-stage immediate controller.
//   - opcode constants (instr[15:11])
//   - immediate select encodings (bit 3 = sign-extend, bits [2:0] = field)
//   - skid-buffer entry struct and occupancy state enum
//   - NOP_INSTR, the word presented when no entry is valid
package imm_pkg;

  localparam logic [4:0] OP_ADDSP3   = 5'b00000;
  localparam logic [4:0] OP_B        = 5'b00010;
  localparam logic [4:0] OP_BEQZ     = 5'b00100;
  localparam logic [4:0] OP_BNEZ     = 5'b00101;
  localparam logic [4:0] OP_SHIFT    = 5'b00110;
  localparam logic [4:0] OP_ADDIU3   = 5'b01000;
  localparam logic [4:0] OP_ADDIU    = 5'b01001;
  localparam logic [4:0] OP_ADDSP_BT = 5'b01100;  // ADDSP / BTEQZ share the opcode
  localparam logic [4:0] OP_LI       = 5'b01101;
  localparam logic [4:0] OP_CMPI     = 5'b01110;
  localparam logic [4:0] OP_LW_SP    = 5'b10010;
  localparam logic [4:0] OP_LW       = 5'b10011;
  localparam logic [4:0] OP_SW_SP    = 5'b11010;
  localparam logic [4:0] OP_SW       = 5'b11011;

  localparam logic [3:0] IMM_U8    = 4'b0000;
  localparam logic [3:0] IMM_S8    = 4'b1000;
  localparam logic [3:0] IMM_S4    = 4'b1001;
  localparam logic [3:0] IMM_S5    = 4'b1010;
  localparam logic [3:0] IMM_S11   = 4'b1011;
  localparam logic [3:0] IMM_SHAMT = 4'b0101;

  localparam logic [15:0] NOP_INSTR = 16'h0800;

  typedef struct packed {
    logic        valid;
    logic [15:0] instr;
    logic [3:0]  sel;
    logic [15:0] imm;
    logic        has_imm;
  } imm_entry_t;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } occ_state_e;

endpackage

// File: rtl/imm_decode_stage_extend.sv
// imm_extend: purely combinational immediate extractor/extender.
//   sel_i   in  4  : immediate select (bit 3 = sign-extend, [2:0] = field)
//   instr_i in  16 : instruction word
//   imm_o   out 16 : extended immediate
module imm_extend
  import imm_pkg::*;
(
  input  logic [3:0]  sel_i,
  input  logic [15:0] instr_i,
  output logic [15:0] imm_o
);

  logic sx;
  assign sx = sel_i[3];

  always_comb begin
    imm_o = '0;
    case (sel_i[2:0])
      IMM_U8[2:0]:  imm_o = {{8{sx & instr_i[7]}}, instr_i[7:0]};
      IMM_S4[2:0]:  imm_o = {{12{sx & instr_i[3]}}, instr_i[3:0]};
      IMM_S5[2:0]:  imm_o = {{11{sx & instr_i[4]}}, instr_i[4:0]};
      IMM_S11[2:0]: imm_o = {{5{sx & instr_i[10]}}, instr_i[10:0]};
      3'b100:       imm_o = {{13{sx & instr_i[4]}}, instr_i[4:2]};
      // Shift amount: a zero field encodes a shift by 8; never sign-extended.
      IMM_SHAMT[2:0]: begin
        if (instr_i[4:2] == 3'b000) imm_o = 16'd8;
        else                        imm_o = {13'd0, instr_i[4:2]};
      end
      default:      imm_o = '0;
    endcase
  end

endmodule

// File: rtl/imm_decode_stage.sv
// imm_decode_stage: decode-stage immediate controller with a 2-entry skid buffer.
//   clk       in  1  : rising-edge clock
//   rst       in  1  : asynchronous active-low reset
//   in_valid  in  1  / in_ready out 1 : upstream handshake
//   in_instr  in  16 : fetched instruction
//   flush     in  1  : squash all buffered entries (branch taken)
//   out_valid out 1  / out_ready in 1 : downstream handshake
//   instr_out out 16, im_src_sel out 4, imm_out out 16, has_imm out 1 : head entry
module imm_decode_stage #(
  parameter logic [15:0] NOP_INSTR = imm_pkg::NOP_INSTR
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] in_instr,
  input  logic        flush,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] instr_out,
  output logic [3:0]  im_src_sel,
  output logic [15:0] imm_out,
  output logic        has_imm
);
  import imm_pkg::*;

  occ_state_e state_q;
  imm_entry_t head_q;
  imm_entry_t tail_q;

  logic [3:0]  dec_sel;
  logic        dec_has;
  logic [15:0] ext_imm;
  imm_entry_t  new_entry;
  logic        accept;
  logic        pop;

  always_comb begin
    dec_sel = IMM_U8;
    dec_has = 1'b1;
    case (in_instr[15:11])
      OP_ADDIU, OP_ADDSP3, OP_BEQZ, OP_BNEZ,
      OP_CMPI, OP_LW_SP, OP_SW_SP, OP_ADDSP_BT: dec_sel = IMM_S8;
      OP_ADDIU3:                                dec_sel = IMM_S4;
      OP_LW, OP_SW:                             dec_sel = IMM_S5;
      OP_B:                                     dec_sel = IMM_S11;
      OP_LI:                                    dec_sel = IMM_U8;
      OP_SHIFT:                                 dec_sel = IMM_SHAMT;
      default:                                  dec_has = 1'b0;
    endcase
  end

  imm_extend u_extend (
    .sel_i   (dec_sel),
    .instr_i (in_instr),
    .imm_o   (ext_imm)
  );

  always_comb begin
    new_entry.valid   = 1'b1;
    new_entry.instr   = in_instr;
    new_entry.sel     = dec_sel;
    new_entry.imm     = dec_has ? ext_imm : 16'h0000;
    new_entry.has_imm = dec_has;
  end

  // in_ready depends only on state, so out_ready never reaches it combinationally.
  assign in_ready = (state_q != ST_FULL);
  assign accept   = in_valid && in_ready;
  assign pop      = head_q.valid && out_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_EMPTY;
      head_q  <= '0;
      tail_q  <= '0;
    end else if (flush) begin
      // Flush wins over any same-cycle accept or pop.
      state_q <= ST_EMPTY;
      head_q  <= '0;
      tail_q  <= '0;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (accept) begin
            head_q  <= new_entry;
            state_q <= ST_ONE;
          end
        end
        ST_ONE: begin
          if (accept && pop) begin
            head_q <= new_entry;
          end else if (accept) begin
            tail_q  <= new_entry;
            state_q <= ST_FULL;
          end else if (pop) begin
            head_q  <= '0;
            state_q <= ST_EMPTY;
          end
        end
        ST_FULL: begin
          if (pop) begin
            head_q  <= tail_q;
            tail_q  <= '0;
            state_q <= ST_ONE;
          end
        end
        default: begin
          state_q <= ST_EMPTY;
          head_q  <= '0;
          tail_q  <= '0;
        end
      endcase
    end
  end

  assign out_valid  = head_q.valid;
  assign instr_out  = head_q.valid ? head_q.instr : NOP_INSTR;
  assign im_src_sel = head_q.valid ? head_q.sel : 4'd0;
  assign imm_out    = head_q.valid ? head_q.imm : 16'd0;
  assign has_imm    = head_q.valid & head_q.has_imm;

endmodule

// File: tb/tb_imm_decode_stage.sv
module tb_imm_decode_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_instr;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] instr_out;
  logic [3:0]  im_src_sel;
  logic [15:0] imm_out;
  logic        has_imm;

  always #5 clk = ~clk;

  imm_decode_stage #(.NOP_INSTR(16'h0800)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_instr   (in_instr),
    .flush      (flush),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .instr_out  (instr_out),
    .im_src_sel (im_src_sel),
    .imm_out    (imm_out),
    .has_imm    (has_imm)
  );

  typedef struct {
    logic [15:0] instr;
    logic [3:0]  sel;
    logic [15:0] imm;
    logic        has;
  } exp_t;

  exp_t q[$];
  int n_cmp = 0;
  int n_err = 0;

  task automatic check_val(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference decode from the opcode table, using plain integer arithmetic.
  function automatic exp_t ref_decode(input logic [15:0] ins);
    exp_t e;
    int op;
    int v;
    op = int'(ins[15:11]);
    e.instr = ins;
    e.has   = 1'b1;
    e.sel   = 4'd0;
    v       = 0;
    if (op == 9 || op == 0 || op == 4 || op == 5 || op == 14 || op == 18 || op == 26 || op == 12) begin
      e.sel = 4'b1000; v = int'(ins[7:0]); if (v >= 128) v -= 256;
    end else if (op == 8) begin
      e.sel = 4'b1001; v = int'(ins[3:0]); if (v >= 8) v -= 16;
    end else if (op == 19 || op == 27) begin
      e.sel = 4'b1010; v = int'(ins[4:0]); if (v >= 16) v -= 32;
    end else if (op == 2) begin
      e.sel = 4'b1011; v = int'(ins[10:0]); if (v >= 1024) v -= 2048;
    end else if (op == 13) begin
      e.sel = 4'b0000; v = int'(ins[7:0]);
    end else if (op == 6) begin
      e.sel = 4'b0101; v = int'(ins[4:2]); if (v == 0) v = 8;
    end else begin
      e.has = 1'b0;
    end
    e.imm = 16'(v);
    return e;
  endfunction

  task automatic check_outputs();
    exp_t e;
    check_val("in_ready", {15'd0, in_ready}, {15'd0, (q.size() < 2)});
    check_val("out_valid", {15'd0, out_valid}, {15'd0, (q.size() > 0)});
    if (q.size() > 0) e = q[0];
    else begin e.instr = 16'h0800; e.sel = 4'd0; e.imm = 16'd0; e.has = 1'b0; end
    check_val("instr_out", instr_out, e.instr);
    check_val("im_src_sel", {12'd0, im_src_sel}, {12'd0, e.sel});
    check_val("imm_out", imm_out, e.imm);
    check_val("has_imm", {15'd0, has_imm}, {15'd0, e.has});
  endtask

  // Called at a negedge: drive, check current head, clock, update the model.
  task automatic cyc(input logic v, input logic [15:0] ins, input logic fl, input logic ordy);
    logic acc;
    logic pp;
    exp_t e;
    in_valid  = v;
    in_instr  = ins;
    flush     = fl;
    out_ready = ordy;
    check_outputs();
    acc = v && (q.size() < 2);
    pp  = (q.size() > 0) && ordy;
    @(posedge clk);
    if (fl) begin
      q.delete();
      $display("flush");
    end else begin
      if (pp) begin
        e = q.pop_front();
        $display("pop instr=%h sel=%h imm=%h has=%0d", e.instr, e.sel, e.imm, e.has);
      end
      if (acc) q.push_back(ref_decode(ins));
    end
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b0; in_valid = 1'b0; in_instr = 16'h0; flush = 1'b0; out_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check_val("rst_out_valid", {15'd0, out_valid}, 16'd0);
    check_val("rst_in_ready", {15'd0, in_ready}, 16'd1);
    check_val("rst_instr_out", instr_out, 16'h0800);
    check_val("rst_imm_out", imm_out, 16'h0000);
    rst = 1'b1;
    @(negedge clk);

    // ADDIU, shift with zero field, LI
    cyc(1'b1, 16'h4F80, 1'b0, 1'b1);
    check_val("addiu_sel", {12'd0, im_src_sel}, 16'h0008);
    check_val("addiu_imm", imm_out, 16'hFF80);
    check_val("addiu_has", {15'd0, has_imm}, 16'd1);
    cyc(1'b1, 16'h3000, 1'b0, 1'b1);
    check_val("sll_sel", {12'd0, im_src_sel}, 16'h0005);
    check_val("sll_imm", imm_out, 16'h0008);
    cyc(1'b1, 16'h6DFF, 1'b0, 1'b1);
    check_val("li_sel", {12'd0, im_src_sel}, 16'h0000);
    check_val("li_imm", imm_out, 16'h00FF);
    cyc(1'b0, 16'h0000, 1'b0, 1'b1);

    // Back-pressure: B then SW with out_ready low for 3 cycles
    cyc(1'b1, 16'h1400, 1'b0, 1'b0);
    cyc(1'b1, 16'hDF10, 1'b0, 1'b0);
    check_val("bp_in_ready", {15'd0, in_ready}, 16'd0);
    cyc(1'b1, 16'h6D11, 1'b0, 1'b0);
    check_val("bp_b_instr", instr_out, 16'h1400);
    check_val("bp_b_imm", imm_out, 16'hFC00);
    cyc(1'b0, 16'h0000, 1'b0, 1'b1);
    check_val("bp_sw_instr", instr_out, 16'hDF10);
    check_val("bp_sw_imm", imm_out, 16'hFFF0);
    cyc(1'b0, 16'h0000, 1'b0, 1'b1);

    // Flush while full with in_valid high, then flush against accept+pop
    cyc(1'b1, 16'h4F80, 1'b0, 1'b0);
    cyc(1'b1, 16'h6DFF, 1'b0, 1'b0);
    cyc(1'b1, 16'h1400, 1'b1, 1'b0);
    check_val("fl_out_valid", {15'd0, out_valid}, 16'd0);
    check_val("fl_in_ready", {15'd0, in_ready}, 16'd1);
    check_val("fl_instr_out", instr_out, 16'h0800);
    cyc(1'b1, 16'h4F80, 1'b0, 1'b0);
    cyc(1'b1, 16'h6DFF, 1'b1, 1'b1);
    check_val("fl2_out_valid", {15'd0, out_valid}, 16'd0);

    // Asynchronous reset while full
    cyc(1'b1, 16'h4F80, 1'b0, 1'b0);
    cyc(1'b1, 16'h6DFF, 1'b0, 1'b0);
    in_valid = 1'b0;
    #2 rst = 1'b0;
    #1;
    check_val("arst_out_valid", {15'd0, out_valid}, 16'd0);
    check_val("arst_in_ready", {15'd0, in_ready}, 16'd1);
    check_val("arst_instr_out", instr_out, 16'h0800);
    check_val("arst_imm_out", imm_out, 16'h0000);
    check_val("arst_sel", {12'd0, im_src_sel}, 16'h0000);
    check_val("arst_has", {15'd0, has_imm}, 16'd0);
    q.delete();
    @(negedge clk);
    rst = 1'b1;
    cyc(1'b1, 16'h1400, 1'b0, 1'b1);
    check_val("arst_first", instr_out, 16'h1400);

    // Random traffic over all opcodes
    for (int i = 0; i < 600; i++) begin
      cyc(($urandom % 4) != 0, 16'($urandom), ($urandom % 25) == 0, ($urandom % 3) != 0);
    end
    for (int i = 0; i < 4; i++) cyc(1'b0, 16'h0000, 1'b0, 1'b1);
    check_outputs();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
